// File: rtl/writer_if.sv
// Handshake and serial-output bundle for the writer parallel-to-serial stage.
// The master side loads words; the slave side is the writer itself.
interface writer_if #(
    parameter int width = 32
);
    logic             start;
    logic [width-1:0] din;
    logic             hold;
    logic             so;
    logic             shift_en;
    logic             busy;
    logic             done;

    modport master (
        output start, din, hold,
        input  so, shift_en, busy, done
    );

    modport slave (
        input  start, din, hold,
        output so, shift_en, busy, done
    );
endinterface

// File: rtl/writer.sv
// Parallel-in, serial-out stage: loads one word on start and streams it MSB-first
// with a shift_en strobe for the downstream reader; supports stalls and abort.
module writer #(
    parameter int width = 32
) (
    input  logic     clk,
    input  logic     clear,
    writer_if.slave  bus
);
    localparam int CW = $clog2(width + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_reg;
    logic [width-1:0] data_reg;
    logic [CW-1:0]    count_reg;
    logic             done_reg;

    // busy and done come straight from flops; only shift_en depends on hold.
    assign bus.busy     = (state_reg == SHIFT);
    assign bus.shift_en = (state_reg == SHIFT) && !bus.hold;
    assign bus.so       = data_reg[width-1];
    assign bus.done     = done_reg;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        data_reg  <= bus.din;
                        count_reg <= CW'(width);
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!bus.hold) begin
                        // Zero-fill so so reads 0 once the frame has drained.
                        data_reg  <= {data_reg[width-2:0], 1'b0};
                        count_reg <= count_reg - 1'b1;
                        if (count_reg == CW'(1)) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writer.sv
// Self-checking bench for writer: 32-bit and 8-bit instances, scoreboard of
// expected serial bits plus a model of the downstream reader register.
module tb_writer;
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    writer_if #(.width(32)) b32 ();
    writer_if #(.width(8))  b8 ();

    writer #(.width(32)) dut32 (.clk(clk), .clear(clear), .bus(b32.slave));
    writer #(.width(8))  dut8  (.clk(clk), .clear(clear), .bus(b8.slave));

    int n_cmp = 0;
    int n_bad = 0;
    logic q32[$];
    logic q8[$];
    logic [31:0] rdr32 = '0;
    logic [7:0]  rdr8  = '0;

    // Reader model: a bit strobed in this cycle is captured at the next edge.
    always @(negedge clk) begin
        if (b32.shift_en) rdr32 <= {rdr32[30:0], b32.so};
        if (b8.shift_en)  rdr8  <= {rdr8[6:0], b8.so};
    end

    typedef struct {
        logic [31:0] din;
        int          hold_at;
        int          hold_len;
        int          junk_at;
        bit          b2b;
        bit          nxt;
        logic [31:0] nd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge.
    task automatic run_frame(input vec_t v);
        int last;
        int c0;
        int done_c;
        bit exp_busy;
        bit exp_en;
        last   = 32 + v.hold_len + 1;
        c0     = v.b2b ? 1 : 0;
        done_c = -1;
        if (v.b2b) for (int i = 31; i >= 0; i--) q32.push_back(v.din[i]);
        for (int c = c0; c <= last; c++) begin
            b32.start = (c == 0) || (c == v.junk_at) || (c == last && v.nxt);
            b32.din   = (c == 0) ? v.din : ((c == last && v.nxt) ? v.nd : 32'hFFFF_FFFF);
            b32.hold  = (v.hold_len > 0) && (c > v.hold_at) && (c <= v.hold_at + v.hold_len);
            if (c == 0) for (int i = 31; i >= 0; i--) q32.push_back(v.din[i]);
            @(negedge clk);
            exp_busy = (c >= 1) && (c < last);
            exp_en   = exp_busy && !b32.hold;
            chk("busy", 32'(b32.busy), 32'(exp_busy));
            chk("shift_en", 32'(b32.shift_en), 32'(exp_en));
            chk("done", 32'(b32.done), 32'(c == last));
            if (b32.done) done_c = c;
            if (exp_busy) begin
                if (q32.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
                else begin
                    chk("so", 32'(b32.so), 32'(q32[0]));
                    if (exp_en) void'(q32.pop_front());
                end
            end
            if (c == 0 || c == last) chk("so_idle", 32'(b32.so), 32'd0);
            if (c == last) begin
                chk("reader", rdr32, v.din);
                chk("bits_left", 32'(q32.size()), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        b32.start = 1'b0;
        b32.hold  = 1'b0;
        $display("frame din=%h holds=%0d done_cycle=%0d reader=%h", v.din, v.hold_len, done_c, rdr32);
    endtask

    vec_t vecs[6];
    logic [7:0] d8;

    initial begin
        vecs[0] = '{32'hA5A5_0F0F, 0,  0, -1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{32'hA5A5_0F0F, 10, 5, -1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{32'h1234_5678, 0,  0, 8,  1'b0, 1'b0, 32'h0};
        vecs[3] = '{32'hDEAD_BEEF, 0,  0, -1, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[4] = '{32'hCAFE_F00D, 0,  0, -1, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{32'hFFFF_FFFF, 31, 3, -1, 1'b0, 1'b0, 32'h0};

        b32.start = 1'b0; b32.din = '0; b32.hold = 1'b0;
        b8.start  = 1'b0; b8.din  = '0; b8.hold  = 1'b0;
        clear = 1'b1;
        #1;
        chk("rst_busy", 32'(b32.busy), 32'd0);
        chk("rst_shift_en", 32'(b32.shift_en), 32'd0);
        chk("rst_so", 32'(b32.so), 32'd0);
        chk("rst_done", 32'(b32.done), 32'd0);
        chk("rst8_busy", 32'(b8.busy), 32'd0);
        @(posedge clk);
        #2 clear = 1'b0;
        // hold in IDLE must not start anything
        b32.hold = 1'b1;
        @(negedge clk);
        chk("idle_hold_busy", 32'(b32.busy), 32'd0);
        chk("idle_hold_en", 32'(b32.shift_en), 32'd0);
        b32.hold = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) run_frame(vecs[k]);

        // Asynchronous abort while bit 12 is on the line.
        b32.din = 32'h0F0F_1234;
        b32.start = 1'b1;
        @(posedge clk);
        #1 b32.start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        chk("pre_abort_busy", 32'(b32.busy), 32'd1);
        clear = 1'b1;
        #1;
        chk("abort_busy", 32'(b32.busy), 32'd0);
        chk("abort_shift_en", 32'(b32.shift_en), 32'd0);
        chk("abort_so", 32'(b32.so), 32'd0);
        chk("abort_done", 32'(b32.done), 32'd0);
        @(posedge clk);
        #2 clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(b32.done), 32'd0);
            chk("abort_idle", 32'(b32.busy), 32'd0);
        end
        @(posedge clk);
        #1;
        q32.delete();
        run_frame('{32'h0000_0001, 0, 0, -1, 1'b0, 1'b0, 32'h0});

        // Narrow instance.
        d8 = 8'h81;
        for (int i = 7; i >= 0; i--) q8.push_back(d8[i]);
        for (int c = 0; c <= 9; c++) begin
            b8.start = (c == 0);
            b8.din   = d8;
            @(negedge clk);
            chk("w8_shift_en", 32'(b8.shift_en), 32'((c >= 1) && (c <= 8)));
            chk("w8_done", 32'(b8.done), 32'(c == 9));
            if (b8.shift_en) begin
                if (q8.size() == 0) chk("w8_scoreboard_empty", 32'd1, 32'd0);
                else chk("w8_so", 32'(b8.so), 32'(q8.pop_front()));
            end
            if (c == 9) chk("w8_reader", 32'(rdr8), 32'(d8));
            @(posedge clk);
            #1;
        end
        b8.start = 1'b0;
        $display("frame8 din=%h reader=%h", d8, rdr8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
